// File: rtl/aes_wddl_pkg.sv
// Shared types and defaults for the WDDL AES round sequencer.
package aes_wddl_pkg;

    localparam int unsigned AES128_NR         = 10;
    localparam int unsigned DEFAULT_RW        = 4;
    localparam int unsigned DEFAULT_PRECH_CYC = 1;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StPre,
        StWaitk,
        StEval,
        StFin
    } state_e;

    typedef struct packed {
        logic ld_r;
        logic prech;
        logic eval;
        logic kx_req;
        logic busy;
        logic done;
    } ctrl_t;

endpackage

// File: rtl/aes_round_ctrl_wddl.sv
// Round sequencer for the WDDL AES datapath: alternates precharge/evaluate per round
// and handshakes with key expansion before every evaluate phase.
module aes_round_ctrl_wddl
    import aes_wddl_pkg::*;
#(
    parameter int unsigned NR        = AES128_NR,
    parameter int unsigned RW        = DEFAULT_RW,
    parameter int unsigned PRECH_CYC = DEFAULT_PRECH_CYC
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld,
    input  logic          kx_ready,
    output logic          ld_r,
    output logic          prech,
    output logic          eval,
    output logic          kx_req,
    output logic [RW-1:0] round,
    output logic          busy,
    output logic          done
);

    localparam int unsigned   CW        = (PRECH_CYC > 1) ? $clog2(PRECH_CYC) : 1;
    localparam logic [CW-1:0] CntLast   = CW'(PRECH_CYC - 1);
    localparam logic [RW-1:0] RoundLast = RW'(NR);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] round_q, round_d;
    ctrl_t         ctrl_q, ctrl_d;
    logic          pre_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            round_q <= '0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            round_q <= round_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign pre_last = (state_q == StPre) && (cnt_q == CntLast);

    // kx_ready only matters on the last precharge cycle and while waiting for the key.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        round_d = round_q;
        unique case (state_q)
            StIdle: begin
                if (ld) begin
                    state_d = StLoad;
                    round_d = '0;
                end
            end
            StLoad: state_d = StPre;
            StPre: begin
                if (pre_last) begin
                    state_d = kx_ready ? StEval : StWaitk;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWaitk: begin
                if (kx_ready) begin
                    state_d = StEval;
                end
            end
            StEval: begin
                if (round_q == RoundLast) begin
                    state_d = StFin;
                end else begin
                    state_d = StPre;
                    round_d = round_q + 1'b1;
                end
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Decoded from the next state so every output is a flop aligned with state_q.
    always_comb begin
        ctrl_d = '0;
        unique case (state_d)
            StLoad: begin
                ctrl_d.ld_r   = 1'b1;
                ctrl_d.prech  = 1'b1;
                ctrl_d.kx_req = 1'b1;
                ctrl_d.busy   = 1'b1;
            end
            StPre, StWaitk: begin
                ctrl_d.prech  = 1'b1;
                ctrl_d.kx_req = 1'b1;
                ctrl_d.busy   = 1'b1;
            end
            StEval: begin
                ctrl_d.eval = 1'b1;
                ctrl_d.busy = 1'b1;
            end
            StFin: begin
                ctrl_d.prech = 1'b1;
                ctrl_d.busy  = 1'b1;
                ctrl_d.done  = 1'b1;
            end
            default: ctrl_d = '0;
        endcase
    end

    assign ld_r   = ctrl_q.ld_r;
    assign prech  = ctrl_q.prech;
    assign eval   = ctrl_q.eval;
    assign kx_req = ctrl_q.kx_req;
    assign busy   = ctrl_q.busy;
    assign done   = ctrl_q.done;
    assign round  = round_q;

endmodule

// File: tb/tb_aes_round_ctrl_wddl.sv
// Directed bench for aes_round_ctrl_wddl: one instance with PRECH_CYC=1, one with PRECH_CYC=3.
module tb_aes_round_ctrl_wddl;

    localparam int NR = 10;

    // {ld_r, prech, eval, kx_req, busy, done}
    localparam logic [5:0] V_IDLE = 6'b000000;
    localparam logic [5:0] V_LOAD = 6'b110110;
    localparam logic [5:0] V_PRE  = 6'b010110;
    localparam logic [5:0] V_EVAL = 6'b001010;
    localparam logic [5:0] V_FIN  = 6'b010011;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ld = 1'b0, kx_ready = 1'b1;
    logic       ld3 = 1'b0, kx3 = 1'b1;
    logic       ld_r, prech, eval, kx_req, busy, done;
    logic       ld_r3, prech3, eval3, kx_req3, busy3, done3;
    logic [3:0] round, round3;
    logic [5:0] vec1, vec3, ev;
    logic [3:0] er;

    int n_checks = 0;
    int n_errors = 0;

    assign vec1 = {ld_r, prech, eval, kx_req, busy, done};
    assign vec3 = {ld_r3, prech3, eval3, kx_req3, busy3, done3};

    always #5 clk = ~clk;

    aes_round_ctrl_wddl #(.NR(NR), .RW(4), .PRECH_CYC(1)) dut (
        .clk(clk), .rst(rst), .ld(ld), .kx_ready(kx_ready),
        .ld_r(ld_r), .prech(prech), .eval(eval), .kx_req(kx_req),
        .round(round), .busy(busy), .done(done)
    );

    aes_round_ctrl_wddl #(.NR(NR), .RW(4), .PRECH_CYC(3)) dut3 (
        .clk(clk), .rst(rst), .ld(ld3), .kx_ready(kx3),
        .ld_r(ld_r3), .prech(prech3), .eval(eval3), .kx_req(kx_req3),
        .round(round3), .busy(busy3), .done(done3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs k cycles after ld acceptance, PRECH_CYC=1, key always ready.
    function automatic void exp1(input int k, output logic [5:0] v, output logic [3:0] r);
        if (k == 1) begin
            v = V_LOAD; r = 4'd0;
        end else if (k == 2 * NR + 4) begin
            v = V_FIN; r = 4'(NR);
        end else if (k % 2 == 1) begin
            v = V_EVAL; r = 4'((k - 3) / 2);
        end else begin
            v = V_PRE; r = 4'((k - 2) / 2);
        end
    endfunction

    initial begin
        int  n_eval;
        bit  got_done;
        logic prev_eval, prev_kx;

        // Reset while idle
        repeat (2) @(posedge clk);
        #1;
        chk("rst_idle_vec", 32'(vec1), 32'(V_IDLE));
        chk("rst_idle_round", 32'(round), 0);
        chk("rst_idle_vec3", 32'(vec3), 32'(V_IDLE));
        rst = 1'b0;
        step();
        chk("idle_vec", 32'(vec1), 32'(V_IDLE));

        // Nominal run, with ld pulses while busy and on done that must be ignored
        ld = 1'b1;
        step();
        ld = 1'b0;
        for (int k = 1; k <= 2 * NR + 4; k++) begin
            exp1(k, ev, er);
            chk($sformatf("run1_vec_k%0d", k), 32'(vec1), 32'(ev));
            chk($sformatf("run1_round_k%0d", k), 32'(round), 32'(er));
            chk($sformatf("run1_xor_k%0d", k), 32'(prech ^ eval), 1);
            ld = (k == 5 || k == 2 * NR + 4);
            step();
        end
        ld = 1'b0;
        chk("run1_idle_after_done", 32'(vec1), 32'(V_IDLE));

        // ld in IDLE right after done starts a new run; reset it mid-round at EVAL round 5
        ld = 1'b1;
        step();
        ld = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            exp1(k, ev, er);
            chk($sformatf("run2_vec_k%0d", k), 32'(vec1), 32'(ev));
            chk($sformatf("run2_round_k%0d", k), 32'(round), 32'(er));
            if (k < 13) step();
        end
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_vec_async", 32'(vec1), 32'(V_IDLE));
        chk("rst_mid_round_async", 32'(round), 0);
        step();
        chk("rst_mid_vec", 32'(vec1), 32'(V_IDLE));
        chk("rst_mid_round", 32'(round), 0);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("post_rst_idle_%0d", k), 32'(vec1), 32'(V_IDLE));
        end

        // Key not ready for 4 cycles at round 3
        ld = 1'b1;
        step();
        ld = 1'b0;
        for (int k = 1; k <= 2 * NR + 8; k++) begin
            if (k <= 8) begin
                exp1(k, ev, er);
            end else if (k <= 12) begin
                ev = V_PRE; er = 4'd3;
            end else begin
                exp1(k - 4, ev, er);
            end
            chk($sformatf("waitk_vec_k%0d", k), 32'(vec1), 32'(ev));
            chk($sformatf("waitk_round_k%0d", k), 32'(round), 32'(er));
            kx_ready = !(k >= 8 && k <= 11);
            step();
        end
        kx_ready = 1'b1;
        chk("waitk_idle_after_done", 32'(vec1), 32'(V_IDLE));

        // kx_ready toggling every cycle
        kx_ready = 1'b0;
        prev_kx = 1'b0;
        ld = 1'b1;
        step();
        ld = 1'b0;
        n_eval = 0;
        got_done = 1'b0;
        prev_eval = 1'b0;
        for (int k = 1; k <= 80 && !got_done; k++) begin
            chk($sformatf("toggle_no_double_eval_k%0d", k), 32'(eval && prev_eval), 0);
            if (eval) begin
                n_eval++;
                chk($sformatf("toggle_eval_needs_kx_k%0d", k), 32'(prev_kx), 1);
            end
            if (done) begin
                got_done = 1'b1;
                chk("toggle_eval_count", 32'(n_eval), 32'(NR + 1));
                chk("toggle_done_round", 32'(round), 32'(NR));
            end
            prev_eval = eval;
            kx_ready = ~kx_ready;
            prev_kx = kx_ready;
            step();
        end
        chk("toggle_done_seen", 32'(got_done), 1);
        kx_ready = 1'b1;

        // PRECH_CYC=3 instance: 3 precharge cycles between evaluations, done at cycle 46
        step();
        ld3 = 1'b1;
        step();
        ld3 = 1'b0;
        for (int k = 1; k <= 46; k++) begin
            if (k == 1) begin
                ev = V_LOAD; er = 4'd0;
            end else if (k == 46) begin
                ev = V_FIN; er = 4'(NR);
            end else if (k >= 5 && (k - 5) % 4 == 0) begin
                ev = V_EVAL; er = 4'((k - 5) / 4);
            end else begin
                ev = V_PRE; er = 4'((k - 2) / 4);
            end
            chk($sformatf("p3_vec_k%0d", k), 32'(vec3), 32'(ev));
            chk($sformatf("p3_round_k%0d", k), 32'(round3), 32'(er));
            step();
        end
        chk("p3_idle_after_done", 32'(vec3), 32'(V_IDLE));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
